// File: rtl/bitserial_alu_ctrl.sv
// bitserial_alu_ctrl
// Sequencer that runs one external 1-bit slice over a WIDTH-bit operand pair,
// LSB first, one bit per clock. The slice's cout is fed back as the next
// cycle's cin, and the slice's q bits are assembled into the result word.
//
// Optional feature: define BITSERIAL_ABORT_EN to add an `abort` input that
// cancels an operation in flight (no done pulse, result and carry_out cleared).
module bitserial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef BITSERIAL_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_op1,
  output logic             slice_op0,
  input  logic             slice_q,
  input  logic             slice_cout
);

  // Bit counter only needs to reach WIDTH-1.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_sh;
  logic             carry_reg;
  logic             carry_out_reg;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_bit;
  logic             abort_hit;

`ifdef BITSERIAL_ABORT_EN
  // Abort only has meaning while an operation is in flight.
  assign abort_hit = abort && (state == RUN);
`else
  assign abort_hit = 1'b0;
`endif

  assign last_bit = (cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, handshake outputs and slice drive.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_cin  = 1'b0;
    slice_op1  = 1'b0;
    slice_op0  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end

      RUN: begin
        busy      = 1'b1;
        slice_a   = a_sh[0];
        slice_b   = b_sh[0];
        slice_cin = carry_reg;
        slice_op1 = op_reg[1];
        slice_op0 = op_reg[0];
        // Abort wins over completion on the final bit.
        if (abort_hit) begin
          state_next = IDLE;
        end else if (last_bit) begin
          state_next = DONE;
        end
      end

      DONE: begin
        done = 1'b1;
        // Back-to-back: operands presented in the DONE cycle are accepted.
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latching, bit-serial shifting, carry feedback and result assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath is only a few flops, so it is fully reset; this
      // keeps result/carry_out defined (zero) immediately after reset.
      op_reg        <= 2'b00;
      a_sh          <= '0;
      b_sh          <= '0;
      result_sh     <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      cnt           <= '0;
    end else if (accept) begin
      // Result and carry_out keep their old values until RUN overwrites them.
      op_reg    <= op;
      a_sh      <= a_in;
      b_sh      <= b_in;
      carry_reg <= cin_init;
      cnt       <= '0;
    end else if (state == RUN) begin
      if (abort_hit) begin
        result_sh     <= '0;
        carry_out_reg <= 1'b0;
        carry_reg     <= 1'b0;
        cnt           <= '0;
      end else begin
        result_sh <= {slice_q, result_sh[WIDTH-1:1]};
        a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
        carry_reg <= slice_cout;
        if (last_bit) begin
          // Counter parks at WIDTH-1; the next accept clears it.
          carry_out_reg <= slice_cout;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign result    = result_sh;
  assign carry_out = carry_out_reg;

endmodule

// File: doc/bitserial_alu_ctrl.md
# bitserial_alu_ctrl

Sequencer that runs one 1-bit `bitwiseblock` slice over a WIDTH-bit operand pair, LSB first, one bit per clock. Each cycle it presents one operand bit pair to the slice and feeds the previous cycle's `cout` back as `cin`. It assembles `q` into a result word. It sits between the register file and a single shared slice, giving the CPU full-width bitwise/arithmetic results at minimal gate count.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal values 2..32.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE or DONE.
- `op`  in  2  slice operation code; latched at accept, driven to `slice_op1`/`slice_op0` (`op[1]`→`op1`).
- `a_in`  in  WIDTH  operand A; latched at accept.
- `b_in`  in  WIDTH  operand B; latched at accept.
- `cin_init`  in  1  carry-in for bit 0; latched at accept.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `result`  out  WIDTH  assembled q word; stable from DONE until next accept.
- `carry_out`  out  1  final slice `cout` of bit WIDTH-1.
- `slice_a`, `slice_b`, `slice_cin`, `slice_op1`, `slice_op0`  out  1 each  drive to slice.
- `slice_q`, `slice_cout`  in  1 each  from slice (combinational).

## Operation
- Clocking and reset are fixed: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - all slice outputs 0;
  - `start`=1 → latch `op`, `a_in`, `b_in`, `cin_init` into shift regs/carry reg; bit counter=0; go RUN.
- RUN:
  - combinational drive: `slice_a`=A_sh[0], `slice_b`=B_sh[0], `slice_cin`=carry_reg, `slice_op1/0`=latched op.
  - each edge: result_sh ← {`slice_q`, result_sh[WIDTH-1:1]}; carry_reg ← `slice_cout`; A_sh, B_sh shift right 1 (zero fill); counter+1.
  - counter reaches WIDTH-1 on the current edge → go DONE; that edge also captures the final bit.
- DONE:
  - `done`=1 for exactly this cycle; `carry_out`=carry_reg.
  - `start`=1 → accept as in IDLE, go RUN (back-to-back); otherwise go IDLE.
- `start` in RUN is ignored; in-flight operands are unaffected.
- `result` and `carry_out` hold their last values in IDLE; they change only during RUN.
- Counter width is clog2(WIDTH); it never wraps past WIDTH-1.
- Reset at any time, including mid-RUN: next state IDLE; `busy`=0, `done`=0, `result`=0, `carry_out`=0, carry_reg=0, counter=0, and all slice outputs 0.

## Timing
- Start accepted at edge E0.
- RUN covers cycles E0..E0+WIDTH-1; bit i is presented to the slice during cycle E0+i.
- `done` is high in cycle E0+WIDTH.
- Latency from start to done is WIDTH+1 cycles.
- Back-to-back throughput is one result per WIDTH+1 cycles.
- The slice path is combinational within one cycle: controller regs → slice → controller regs. No slice output is registered externally.
- `busy` is low in the DONE cycle.

## Configuration
- Macro: `BITSERIAL_ABORT_EN`.
- Defined:
  - adds input port `abort` (1 bit).
  - `abort`=1 in RUN → next state IDLE; no `done` pulse; `result`=0 and `carry_out`=0.
  - `abort` takes priority over the final-bit transition.
  - `abort` is ignored in IDLE and DONE.
- Undefined: `abort` port is absent, and RUN always completes.

## Test plan
All scenarios use a bench slice model with q=a^b^cin and cout=majority(a,b,cin).
- Reset: WIDTH=8, `a_in`=0xA5, `b_in`=0x3C, `cin_init`=0, pulse `start` → `done` at cycle 9, `result`=0xE1, `carry_out`=0.
- Carry ripple: `a_in`=0xFF, `b_in`=0x01, `cin_init`=0 → `result`=0x00, `carry_out`=1. Also check per-cycle `slice_cin` sequence 0,1,1,1,1,1,1,1.
- Op passthrough and ignore-start: `op`=2'b10 → `slice_op1`=1 and `slice_op0`=0 throughout RUN. Change `op` and `a_in` and pulse `start` mid-RUN → result is unaffected.
- Back-to-back: `start` held high → `done` pulses every 9 cycles. Second result uses operands sampled in the DONE cycle: 0x01+0x01 → 0x02.
- Reset mid-op: assert `rst` at RUN bit 4 → next cycle `busy`=0, `result`=0, no `done`. A new start then completes normally.
- With `BITSERIAL_ABORT_EN`: `abort` at bit 7 (final cycle) → IDLE, no `done`, `result`=0.
